// File: rtl/nx_arb_pkg.sv
// Shared arbitration types and the rotating priority encoder used by the nx_fifo
// write arbiter and the read-side schedulers.
package nx_arb_pkg;

    localparam int unsigned RR_MAX_REQ = 16;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    // Rotate valid so ptr lands on bit 0, pick the lowest set bit, rotate the index back.
    function automatic int unsigned rr_pick(
        input logic [RR_MAX_REQ-1:0] valid,
        input logic [3:0]            ptr,
        input int unsigned           n
    );
        logic [RR_MAX_REQ-1:0] rot;
        logic [4:0]            src;
        logic [4:0]            dst;
        logic [3:0]            enc;
        logic                  hit;
        rot = '0;
        for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
            if (i < n) begin
                src = 5'(i) + {1'b0, ptr};
                if (src >= 5'(n)) begin
                    src = src - 5'(n);
                end
                rot[i] = valid[src[3:0]];
            end
        end
        enc = '0;
        hit = 1'b0;
        for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
            if (!hit && rot[i]) begin
                hit = 1'b1;
                enc = 4'(i);
            end
        end
        dst = {1'b0, enc} + {1'b0, ptr};
        if (dst >= 5'(n)) begin
            dst = dst - 5'(n);
        end
        return 32'(dst);
    endfunction

endpackage

// File: rtl/nx_rr_pick_comb.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
module nx_rr_pick_comb
    import nx_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         valid,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     found,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int unsigned IW = $clog2(N_REQ);

    logic [RR_MAX_REQ-1:0] valid_ext;
    logic [3:0]            ptr_ext;
    int unsigned           pick;

    always_comb begin
        valid_ext = RR_MAX_REQ'(valid);
        ptr_ext   = 4'(ptr);
        pick      = rr_pick(valid_ext, ptr_ext, N_REQ);
        idx       = IW'(pick);
        found     = |valid;
    end

endmodule

// File: rtl/nx_fifo_wr_arb.sv
// Round-robin write arbiter with burst lock sharing one nx_fifo write port
// between N_REQ valid/ready/last producers.
module nx_fifo_wr_arb
    import nx_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned WIDTH     = 83,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_last,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_wen,
    output logic [WIDTH-1:0]         fifo_wdata,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     err_overflow
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    arb_state_e     state, state_nx;
    logic [IW-1:0]  rr_ptr, rr_ptr_nx;
    logic [IW-1:0]  owner_nx;
    logic [CW-1:0]  beat_cnt, beat_cnt_nx;
    logic           err_nx;

    logic           pick_found;
    logic [IW-1:0]  pick_idx;
    logic [IW-1:0]  gnt;
    logic           gnt_valid;
    logic           accept;
    logic           burst_end;
    logic [IW-1:0]  gnt_inc;

    nx_rr_pick_comb #(
        .N_REQ(N_REQ)
    ) u_pick (
        .valid(req_valid),
        .ptr  (rr_ptr),
        .found(pick_found),
        .idx  (pick_idx)
    );

    // Grant and accept; everything is gated by rst_n so outputs sit low during reset.
    always_comb begin
        gnt       = (state == ARB_IDLE) ? pick_idx : owner;
        gnt_valid = (state == ARB_IDLE) ? pick_found : 1'b1;
        accept    = rst_n & ~clear & ~fifo_full & gnt_valid & req_valid[gnt];
        if (state == ARB_IDLE) begin
            burst_end = req_last[gnt] | (MAX_BURST == 1);
        end else begin
            burst_end = req_last[gnt] | (beat_cnt == CW'(MAX_BURST - 1));
        end
        gnt_inc = (gnt == IW'(N_REQ - 1)) ? '0 : gnt + 1'b1;
    end

    always_comb begin
        req_ready  = '0;
        fifo_wdata = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (accept && gnt == IW'(i)) begin
                req_ready[i] = 1'b1;
                fifo_wdata   = req_data[i*WIDTH +: WIDTH];
            end
        end
        fifo_wen = accept;
        busy     = rst_n & (state == ARB_LOCKED);
    end

    always_comb begin
        state_nx    = state;
        rr_ptr_nx   = rr_ptr;
        owner_nx    = owner;
        beat_cnt_nx = beat_cnt;
        err_nx      = err_overflow | (fifo_wen & fifo_full);
        if (clear) begin
            state_nx    = ARB_IDLE;
            rr_ptr_nx   = '0;
            beat_cnt_nx = '0;
        end else if (accept) begin
            owner_nx = gnt;
            if (burst_end) begin
                state_nx    = ARB_IDLE;
                rr_ptr_nx   = gnt_inc;
                beat_cnt_nx = '0;
            end else if (state == ARB_IDLE) begin
                state_nx    = ARB_LOCKED;
                beat_cnt_nx = CW'(1);
            end else begin
                beat_cnt_nx = beat_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ARB_IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            beat_cnt     <= '0;
            err_overflow <= 1'b0;
        end else begin
            state        <= state_nx;
            rr_ptr       <= rr_ptr_nx;
            owner        <= owner_nx;
            beat_cnt     <= beat_cnt_nx;
            err_overflow <= err_nx;
        end
    end

endmodule

// File: tb/tb_nx_fifo_wr_arb.sv
// Directed and randomized bench for nx_fifo_wr_arb against a queue-based
// model of producers, round-robin pointer and burst lock.
module tb_nx_fifo_wr_arb;

    localparam int N  = 4;
    localparam int W  = 83;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           clear;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_full;
    logic           fifo_wen;
    logic [W-1:0]   fifo_wdata;
    logic           busy;
    logic [1:0]     owner;
    logic           err_overflow;

    always #5 clk = ~clk;

    nx_fifo_wr_arb #(
        .N_REQ    (N),
        .WIDTH    (W),
        .MAX_BURST(MB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_wen    (fifo_wen),
        .fifo_wdata  (fifo_wdata),
        .busy        (busy),
        .owner       (owner),
        .err_overflow(err_overflow)
    );

    typedef struct packed {
        logic [W-1:0] d;
        logic         last;
    } beat_t;

    beat_t pq[N][$];
    bit    en[N];
    int    total = 0;
    int    bad   = 0;

    bit    m_locked = 0;
    int    m_owner  = 0;
    int    m_ptr    = 0;
    int    m_cnt    = 0;
    int    grants[$];
    int    exp_seq[16];
    bit    exp_acc;
    int    exp_g;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic add_pkt(input int r, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.d    = W'({$urandom(), $urandom(), $urandom()});
            b.last = (k == len - 1);
            pq[r].push_back(b);
        end
    endtask

    task automatic apply_inputs();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (en[i] && pq[i].size() > 0) begin
                req_valid[i]         = 1'b1;
                req_last[i]          = pq[i][0].last;
                req_data[i*W +: W]   = pq[i][0].d;
            end
        end
    endtask

    task automatic predict_and_check();
        bit           found;
        int           j;
        logic [N-1:0] exp_ready;
        logic [W-1:0] exp_data;
        found = 0;
        exp_g = m_owner;
        if (m_locked) begin
            found = 1;
        end else begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (!found && req_valid[j]) begin
                    found = 1;
                    exp_g = j;
                end
            end
        end
        exp_acc   = rst_n && !clear && !fifo_full && found && req_valid[exp_g];
        exp_ready = '0;
        exp_data  = '0;
        if (exp_acc) begin
            exp_ready[exp_g] = 1'b1;
            exp_data         = pq[exp_g][0].d;
        end
        chk("req_ready", req_ready, exp_ready);
        chk("fifo_wen", fifo_wen, exp_acc);
        chk("fifo_wdata", fifo_wdata, exp_data);
        chk("busy", busy, m_locked);
        chk("owner", owner, m_owner);
        chk("err_overflow", err_overflow, 1'b0);
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_owner  = 0;
        m_ptr    = 0;
        m_cnt    = 0;
    endtask

    task automatic commit();
        beat_t b;
        if (!rst_n) begin
            model_reset();
        end else if (clear) begin
            m_locked = 0;
            m_ptr    = 0;
            m_cnt    = 0;
        end else if (exp_acc) begin
            b = pq[exp_g].pop_front();
            grants.push_back(exp_g);
            m_owner = exp_g;
            m_cnt++;
            if (b.last || m_cnt == MB) begin
                m_locked = 0;
                m_cnt    = 0;
                m_ptr    = (exp_g + 1) % N;
            end else begin
                m_locked = 1;
            end
        end
    endtask

    task automatic step(input int n);
        for (int s = 0; s < n; s++) begin
            apply_inputs();
            @(negedge clk);
            predict_and_check();
            @(posedge clk);
            #1;
            commit();
        end
    endtask

    task automatic check_seq(input string tag, input int n);
        chk({tag, "_count"}, grants.size(), n);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_grant%0d", tag, k), (k < grants.size()) ? grants[k] : -1, exp_seq[k]);
        end
        grants.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, req_ready, '0);
        chk({tag, "_wen"}, fifo_wen, 1'b0);
        chk({tag, "_wdata"}, fifo_wdata, '0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_owner"}, owner, 2'd0);
        chk({tag, "_err"}, err_overflow, 1'b0);
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += pq[i].size();
        return s;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst_n     = 1'b0;
        clear     = 1'b0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) en[i] = 1;

        // Reset: inputs valid but every output must stay low.
        for (int i = 0; i < N; i++) begin
            add_pkt(i, 1);
            add_pkt(i, 1);
            add_pkt(i, 1);
        end
        apply_inputs();
        #7;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: single-beat packets from everyone rotate 0,1,2,3.
        step(12);
        for (int k = 0; k < 12; k++) exp_seq[k] = k % 4;
        check_seq("t1", 12);

        // 2: 3-beat packet from req1 is not interleaved with req2.
        add_pkt(1, 3);
        add_pkt(2, 1);
        step(4);
        exp_seq[0:3] = '{1, 1, 1, 2};
        check_seq("t2", 4);

        clear = 1'b1;
        step(1);
        clear = 1'b0;

        // 3: 10-beat packet is cut every MAX_BURST beats in favour of req3.
        add_pkt(0, 10);
        add_pkt(3, 1);
        add_pkt(3, 1);
        step(12);
        exp_seq[0:11] = '{0, 0, 0, 0, 3, 0, 0, 0, 0, 3, 0, 0};
        check_seq("t3", 12);

        // 4: fifo_full mid-burst freezes the burst without losing beats.
        add_pkt(1, 6);
        add_pkt(2, 1);
        step(2);
        fifo_full = 1'b1;
        step(5);
        fifo_full = 1'b0;
        step(5);
        exp_seq[0:6] = '{1, 1, 1, 1, 2, 1, 1};
        check_seq("t4", 7);

        // 5: owner bubble does not let req2 steal the port.
        add_pkt(3, 4);
        step(1);
        add_pkt(2, 1);
        en[3] = 0;
        step(2);
        en[3] = 1;
        step(4);
        exp_seq[0:4] = '{3, 3, 3, 3, 2};
        check_seq("t5", 5);

        // 6: clear mid-burst, then async reset mid-burst.
        add_pkt(0, 4);
        step(2);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        step(2);
        exp_seq[0:3] = '{0, 0, 0, 0};
        check_seq("t6a", 4);
        add_pkt(1, 4);
        step(2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        step(2);
        rst_n = 1'b1;
        step(2);
        exp_seq[0:3] = '{1, 1, 1, 1};
        check_seq("t6b", 4);

        // Random traffic, stalls and occasional clear, checked cycle by cycle.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (pq[i].size() == 0 && $urandom_range(0, 3) == 0) add_pkt(i, $urandom_range(1, 10));
                en[i] = ($urandom_range(0, 9) != 0);
            end
            fifo_full = ($urandom_range(0, 4) == 0);
            clear     = ($urandom_range(0, 63) == 0);
            step(1);
        end
        fifo_full = 1'b0;
        clear     = 1'b0;
        for (int i = 0; i < N; i++) en[i] = 1;
        guard = 0;
        while (pending() > 0 && guard < 500) begin
            step(1);
            guard++;
        end
        chk("drain_left", pending(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
